// File: rtl/mouse_pkg.sv
// mouse_pkg: constants and types shared by the mouse port adapter.
//   MODE_*    : values of the adapter's mode input
//   ADDR_*    : I/O read-address decode (low 3 bits)
//   step_state_t : per-axis joystick pulse stepper states
package mouse_pkg;

  localparam logic MODE_KEMPSTON = 1'b0;
  localparam logic MODE_JOY      = 1'b1;

  localparam logic [2:0] ADDR_X        = 3'b011;
  localparam logic [2:0] ADDR_Y        = 3'b111;
  // Button port is 3'b?10: compare only the bits set in the mask.
  localparam logic [2:0] ADDR_BTN      = 3'b010;
  localparam logic [2:0] ADDR_BTN_MASK = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } step_state_t;

endpackage

// File: rtl/mouse_axis_stepper.sv
// mouse_axis_stepper: one axis of joystick emulation. Accumulates signed
// mouse motion into a saturating pending count and converts every
// 2^DIV_SHIFT units into one direction pulse (PULSE_LEN high, GAP_LEN low).
//   clk_sys, reset : system clock, synchronous active-high reset
//   clr_i          : clear pending motion and return to idle (mode change)
//   evt_i          : add delta_i to the pending count this cycle
//   delta_i        : 9-bit signed motion delta {sign, byte}
//   pos_pulse      : positive-direction pulse output (registered)
//   neg_pulse      : negative-direction pulse output (registered)
module mouse_axis_stepper
  import mouse_pkg::*;
#(
  parameter int PEND_W    = 10,
  parameter int DIV_SHIFT = 0,
  parameter int PULSE_LEN = 2000,
  parameter int GAP_LEN   = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       evt_i,
  input  logic [8:0] delta_i,
  output logic       pos_pulse,
  output logic       neg_pulse
);

  localparam int SW = ((PEND_W > 9) ? PEND_W : 9) + 2;
  localparam int TW = $clog2(((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) + 1);
  localparam logic signed [SW-1:0] STEP = SW'(2 ** DIV_SHIFT);
  localparam logic signed [SW-1:0] LIM  = SW'(2 ** (PEND_W - 1) - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);

  logic signed [PEND_W-1:0] pend_q, pend_d;
  step_state_t              state_q, state_d;
  logic [TW-1:0]            cnt_q, cnt_d;
  logic                     dir_neg_q, dir_neg_d;

  logic signed [SW-1:0] pend_ext, delta_ext, sum;
  logic                 ready, take_pos, take_neg;

  always_comb begin
    pend_ext  = {{(SW-PEND_W){pend_q[PEND_W-1]}}, pend_q};
    delta_ext = {{(SW-9){delta_i[8]}}, delta_i};

    // The last GAP cycle makes the IDLE decision directly, so back-to-back
    // steps are separated by exactly GAP_LEN low cycles.
    ready    = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == GAP_LAST));
    take_pos = ready && (pend_ext >= STEP);
    take_neg = ready && (pend_ext <= -STEP);

    sum = pend_ext;
    if (evt_i)    sum = sum + delta_ext;
    if (take_pos) sum = sum - STEP;
    if (take_neg) sum = sum + STEP;

    if (sum > LIM)       pend_d = LIM[PEND_W-1:0];
    else if (sum < -LIM) pend_d = -LIM[PEND_W-1:0];
    else                 pend_d = sum[PEND_W-1:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_neg_d = dir_neg_q;
    case (state_q)
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: ;
    endcase

    if (take_pos || take_neg) begin
      state_d   = ST_PULSE;
      cnt_d     = '0;
      dir_neg_d = take_neg;
    end

    if (clr_i) begin
      pend_d  = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir_neg_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_neg_q <= dir_neg_d;
    end
  end

  assign pos_pulse = (state_q == ST_PULSE) && !dir_neg_q;
  assign neg_pulse = (state_q == ST_PULSE) &&  dir_neg_q;

endmodule

// File: rtl/mouse_port_adapter.sv
// mouse_port_adapter: converts MiSTer ps2_mouse packets into a Kempston
// mouse register port (mode=0) or pulsed joystick directions (mode=1).
//   clk_sys, reset : system clock, synchronous active-high reset
//   ps2_mouse      : [24] toggle strobe, [23:16] dy, [15:8] dx,
//                    [5] dy sign, [4] dx sign, [2:0] M/R/L buttons
//   mode           : 0 = Kempston, 1 = joystick emulation
//   addr           : I/O address low bits
//   sel            : port decode hit (combinational)
//   dout           : read data, 8'hFF when sel=0
//   joy_out        : {fire2, fire1, right, left, down, up}, active-high
module mouse_port_adapter
  import mouse_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int DIV_SHIFT = 0,
  parameter int PEND_W    = 10,
  parameter int PULSE_LEN = 2000,
  parameter int GAP_LEN   = 2000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        mode,
  input  logic [2:0]  addr,
  output logic        sel,
  output logic [7:0]  dout,
  output logic [5:0]  joy_out
);

  localparam int AW = CNT_W + DIV_SHIFT;
  localparam logic [AW-1:0] X_RST = AW'(128 * (2 ** DIV_SHIFT));

  logic          toggle_q, mode_q;
  logic [2:0]    btn_q, btn_d;
  logic [1:0]    swap_q, swap_d;
  logic [AW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;

  logic       evt, mode_chg, primary, secondary;
  logic [8:0] dx, dy;
  logic       x_pos, x_neg, y_pos, y_neg;
  logic       unused_bits;

  assign evt       = ps2_mouse[24] ^ toggle_q;
  assign mode_chg  = mode ^ mode_q;
  assign dx        = {ps2_mouse[4], ps2_mouse[15:8]};
  assign dy        = {ps2_mouse[5], ps2_mouse[23:16]};
  assign primary   = btn_q[{1'b0,  swap_q[1]}];
  assign secondary = btn_q[{1'b0, ~swap_q[1]}];
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3]};

  always_comb begin
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    btn_d   = btn_q;
    swap_d  = swap_q;
    if (evt) begin
      x_acc_d = x_acc_q + {{(AW-9){dx[8]}}, dx};
      y_acc_d = y_acc_q + {{(AW-9){dy[8]}}, dy};
      btn_d   = ps2_mouse[2:0];
      if ((swap_q == 2'b00) && (ps2_mouse[1:0] != 2'b00))
        swap_d = ps2_mouse[1:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q <= ps2_mouse[24];
      mode_q   <= mode;
      btn_q    <= '0;
      swap_q   <= '0;
      x_acc_q  <= X_RST;
      y_acc_q  <= '0;
    end else begin
      toggle_q <= ps2_mouse[24];
      mode_q   <= mode;
      btn_q    <= btn_d;
      swap_q   <= swap_d;
      x_acc_q  <= x_acc_d;
      y_acc_q  <= y_acc_d;
    end
  end

  always_comb begin
    sel  = 1'b0;
    dout = '1;
    if (mode == MODE_KEMPSTON) begin
      if (addr == ADDR_X) begin
        sel  = 1'b1;
        dout = x_acc_q[DIV_SHIFT+7:DIV_SHIFT];
      end else if (addr == ADDR_Y) begin
        sel  = 1'b1;
        dout = y_acc_q[DIV_SHIFT+7:DIV_SHIFT];
      end else if ((addr & ADDR_BTN_MASK) == ADDR_BTN) begin
        sel  = 1'b1;
        dout = ~{5'b00000, btn_q[2], primary, secondary};
      end
    end
  end

  mouse_axis_stepper #(
    .PEND_W   (PEND_W),
    .DIV_SHIFT(DIV_SHIFT),
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN)
  ) u_x (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clr_i    (mode_chg),
    .evt_i    (evt && (mode == MODE_JOY)),
    .delta_i  (dx),
    .pos_pulse(x_pos),
    .neg_pulse(x_neg)
  );

  mouse_axis_stepper #(
    .PEND_W   (PEND_W),
    .DIV_SHIFT(DIV_SHIFT),
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN)
  ) u_y (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clr_i    (mode_chg),
    .evt_i    (evt && (mode == MODE_JOY)),
    .delta_i  (dy),
    .pos_pulse(y_pos),
    .neg_pulse(y_neg)
  );

  // Y positive is "up" on the joystick.
  assign joy_out = (mode == MODE_JOY) ? {secondary, primary, x_pos, x_neg, y_neg, y_pos}
                                      : '0;

endmodule

// File: tb/tb_mouse_port_adapter.sv
module tb_mouse_port_adapter;
  import mouse_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        mode;
  logic [2:0]  addr;
  logic        sel0, sel1;
  logic [7:0]  dout0, dout1;
  logic [5:0]  joy0, joy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  mouse_port_adapter #(
    .CNT_W(12), .DIV_SHIFT(0), .PEND_W(8), .PULSE_LEN(4), .GAP_LEN(4)
  ) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .mode(mode),
    .addr(addr), .sel(sel0), .dout(dout0), .joy_out(joy0)
  );

  mouse_port_adapter #(
    .CNT_W(12), .DIV_SHIFT(2), .PEND_W(10), .PULSE_LEN(4), .GAP_LEN(4)
  ) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .mode(mode),
    .addr(addr), .sel(sel1), .dout(dout1), .joy_out(joy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn);
    ps2_mouse = {~ps2_mouse[24], dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 1'b0, btn};
  endtask

  task automatic set_addr(input logic [2:0] a);
    addr = a;
    #1;
  endtask

  logic [7:0]  div_exp [4];
  logic [30:0] rvec, rexp;
  logic [5:0]  other;

  initial begin
    div_exp[0] = 8'h80; div_exp[1] = 8'h80; div_exp[2] = 8'h80; div_exp[3] = 8'h81;
    ps2_mouse = '0;
    mode      = 1'b0;
    addr      = 3'b000;
    reset     = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    set_addr(ADDR_X);
    check_eq("rst_x", 32'(dout0), 32'h80);
    check_eq("rst_sel", 32'(sel0), 32'd1);
    set_addr(ADDR_Y);
    check_eq("rst_y", 32'(dout0), 32'h00);
    check_eq("rst_joy", 32'(joy0), 32'd0);

    send(9'h005, 9'h000, 3'b000); tick(); tick();
    set_addr(ADDR_X); check_eq("x_plus5", 32'(dout0), 32'h85);
    set_addr(ADDR_Y); check_eq("y_after_dx", 32'(dout0), 32'h00);

    send(9'h1FD, 9'h000, 3'b000); tick(); tick();
    set_addr(ADDR_X); check_eq("x_minus3", 32'(dout0), 32'h82);
    send(9'h000, 9'h1FF, 3'b000); tick(); tick();
    set_addr(ADDR_Y); check_eq("y_minus1", 32'(dout0), 32'hFF);
    send(9'h000, 9'h001, 3'b000); tick(); tick();
    set_addr(ADDR_Y); check_eq("y_wrap", 32'(dout0), 32'h00);

    // swap latches 2'b10 -> primary = right (bit1), secondary = left (bit0)
    send(9'h000, 9'h000, 3'b010); tick(); tick();
    set_addr(3'b010); check_eq("btn_right", 32'(dout0), 32'hFD);
    set_addr(3'b110); check_eq("btn_right_alias", 32'(dout0), 32'hFD);
    send(9'h000, 9'h000, 3'b001); tick(); tick();
    set_addr(3'b010); check_eq("btn_left", 32'(dout0), 32'hFE);
    set_addr(3'b000);
    check_eq("nosel_sel", 32'(sel0), 32'd0);
    check_eq("nosel_dout", 32'(dout0), 32'hFF);

    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      send(9'h001, 9'h000, 3'b000); tick(); tick();
      set_addr(ADDR_X);
      check_eq($sformatf("div_x%0d", i), 32'(dout1), 32'(div_exp[i]));
    end
    ps2_mouse[15:8] = 8'h04; tick(); tick();
    set_addr(ADDR_X);
    check_eq("notoggle_div", 32'(dout1), 32'h81);
    check_eq("notoggle_x", 32'(dout0), 32'h84);
    ps2_mouse[15:8] = 8'h00;

    mode = 1'b1; tick(); tick();
    set_addr(ADDR_X);
    check_eq("joy_sel", 32'(sel0), 32'd0);
    check_eq("joy_dout", 32'(dout0), 32'hFF);

    send(9'h003, 9'h000, 3'b000);
    other = '0;
    for (int k = 0; k < 31; k++) begin
      tick();
      rvec[k] = joy0[3];
      other   = other | (joy0 & 6'b110111);
    end
    rexp = '0;
    for (int k = 0; k < 31; k++)
      if ((k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20)) rexp[k] = 1'b1;
    check_eq("right_pulses", 32'(rvec), 32'(rexp));
    check_eq("right_other_bits", 32'(other), 32'd0);
    check_eq("pend_drained", 32'(dut0.u_x.pend_q), 32'd0);

    send(9'h000, 9'h000, 3'b010); tick(); tick();
    check_eq("fire1", 32'(joy0), 32'b010000);
    send(9'h000, 9'h000, 3'b000); tick(); tick();
    check_eq("fire_clear", 32'(joy0), 32'd0);

    send(9'h000, 9'h1FF, 3'b000); tick(); tick();
    check_eq("down_pulse", 32'(joy0), 32'b000010);
    for (int k = 0; k < 10; k++) tick();

    send(9'd100, 9'h000, 3'b000); tick();
    check_eq("pend_100", 32'(dut0.u_x.pend_q), 32'd100);
    send(9'd100, 9'h000, 3'b000); tick();
    check_eq("pend_sat", 32'(dut0.u_x.pend_q), 32'd127);
    check_eq("sat_right", 32'(joy0[3]), 32'd1);
    tick();
    mode = 1'b0; tick();
    check_eq("modechg_pulse", 32'(dut0.u_x.pos_pulse), 32'd0);
    check_eq("modechg_pend", 32'(dut0.u_x.pend_q), 32'd0);
    check_eq("modechg_state", 32'(dut0.u_x.state_q), 32'(ST_IDLE));

    mode = 1'b1; tick(); tick();
    send(9'h002, 9'h000, 3'b000); tick();
    for (int k = 0; k < 6; k++) tick();
    check_eq("mid_gap_state", 32'(dut0.u_x.state_q), 32'(ST_GAP));
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("rst_gap_joy", 32'(joy0), 32'd0);
    check_eq("rst_gap_pend", 32'(dut0.u_x.pend_q), 32'd0);
    check_eq("rst_gap_state", 32'(dut0.u_x.state_q), 32'(ST_IDLE));
    other = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      other = other | joy0;
    end
    check_eq("rst_gap_quiet", 32'(other), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
